// File: rtl/alu_seq_ctrl.sv
// Sequencer that arbitrates two requesters onto one shared multi-cycle ALU and registers its result.
// Optional round-robin arbitration is enabled by defining ALU_SEQ_CTRL_RR_EN (fixed priority to requester 0 otherwise).
module alu_seq_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 8
) (
   input  logic        clock,
   input  logic        clear_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   input  logic [4:0]  req0_op,
   input  logic [4:0]  req1_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [63:0] alu_result,
   output logic [31:0] lo,
   output logic [31:0] hi,
   output logic        resp_valid,
   output logic        resp_id,
   output logic        resp_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;

   logic [1:0]  state;
   logic [3:0]  count;
   logic        owner;
   logic        gnt1;
   logic        accept;
   logic        fin_err;
   logic [4:0]  sel_op;
   logic [31:0] sel_a;
   logic [31:0] sel_b;

   function automatic logic cmd_err(input logic [4:0] op, input logic [31:0] b);
      logic legal;
      legal = (op >= 5'd3 && op <= 5'd11) || (op >= 5'd15 && op <= 5'd18);
      return !legal || (op == OP_DIV && b == 32'd0);
   endfunction

   function automatic logic [3:0] cmd_cycles(input logic [4:0] op, input logic [31:0] b);
      logic [3:0] l;
      l = 4'd1;
      if (!cmd_err(op, b)) begin
         if (op == OP_MUL)      l = 4'(MUL_CYCLES);
         else if (op == OP_DIV) l = 4'(DIV_CYCLES);
      end
      return l;
   endfunction

`ifdef ALU_SEQ_CTRL_RR_EN
   // prio names the requester that wins the next contention; it flips away from whoever was just served
   logic prio;
   assign gnt1 = req1_valid && (!req0_valid || prio);
`else
   assign gnt1 = req1_valid && !req0_valid;
`endif

   assign req0_ready = clear_n && (state == S_IDLE) && req0_valid && !gnt1;
   assign req1_ready = clear_n && (state == S_IDLE) && gnt1;
   assign accept     = req0_ready || req1_ready;

   assign sel_op  = gnt1 ? req1_op : req0_op;
   assign sel_a   = gnt1 ? req1_a  : req0_a;
   assign sel_b   = gnt1 ? req1_b  : req0_b;
   assign fin_err = cmd_err(alu_op, alu_b);

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state      <= S_IDLE;
         count      <= 4'd0;
         owner      <= 1'b0;
         alu_op     <= 5'd0;
         alu_a      <= 32'd0;
         alu_b      <= 32'd0;
         lo         <= 32'd0;
         hi         <= 32'd0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_err   <= 1'b0;
`ifdef ALU_SEQ_CTRL_RR_EN
         prio       <= 1'b0;
`endif
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  alu_op <= sel_op;
                  alu_a  <= sel_a;
                  alu_b  <= sel_b;
                  owner  <= gnt1;
                  count  <= cmd_cycles(sel_op, sel_b) - 4'd1;
                  state  <= S_EXEC;
`ifdef ALU_SEQ_CTRL_RR_EN
                  prio   <= !gnt1;
`endif
               end
            end
            S_EXEC: begin
               if (count == 4'd0) begin
                  // error completions never expose the ALU output
                  lo         <= fin_err ? 32'd0 : alu_result[31:0];
                  hi         <= fin_err ? 32'd0 : alu_result[63:32];
                  resp_err   <= fin_err;
                  resp_id    <= owner;
                  resp_valid <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  count <= count - 4'd1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed literal cases plus randomized traffic checked every cycle against an edge-timeline model.
module tb_alu_seq_ctrl;

   localparam int MUL_C = 4;
   localparam int DIV_C = 8;

   logic        clock = 1'b0;
   logic        clear_n;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready;
   logic [4:0]  alu_op;
   logic [31:0] alu_a, alu_b;
   logic [63:0] alu_result;
   logic [31:0] lo, hi;
   logic        resp_valid, resp_id, resp_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   alu_seq_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
      .clock(clock), .clear_n(clear_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result),
      .lo(lo), .hi(hi),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err)
   );

   // Shared ALU stand-in; a divide by zero returns garbage that must never reach lo/hi.
   function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         5'd3:    return {32'd0, a + b};
         5'd15:   return {32'd0, a} * {32'd0, b};
         5'd16:   return (b == 0) ? 64'hDEADBEEF_DEADBEEF : {a % b, a / b};
         default: return {a ^ 32'h5A5A5A5A, a - b};
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

   // Model: the command accepted at edge k completes (resp_valid visible) after edge k+L; IDLE again after edge k+L+1.
   int          edge_no = 0;
   int          m_idle_from = 0;
   int          m_done_edge = -1;
   logic [4:0]  m_op;
   logic [31:0] m_a, m_b, m_lo, m_hi, p_lo, p_hi;
   logic        m_id, m_err, m_prio, p_id, p_err;
   bit          armed = 0;
   bit          acc_seen;

   function automatic bit is_err(input logic [4:0] op, input logic [31:0] b);
      return !(op inside {[5'd3:5'd11], 5'd15, 5'd16, 5'd17, 5'd18}) || (op == 5'd16 && b == 0);
   endfunction

   function automatic int lat_of(input logic [4:0] op, input logic [31:0] b);
      if (is_err(op, b)) return 1;
      if (op == 5'd15)  return MUL_C;
      if (op == 5'd16)  return DIV_C;
      return 1;
   endfunction

   function automatic logic model_grant();
      if (req0_valid && req1_valid) begin
`ifdef ALU_SEQ_CTRL_RR_EN
         return m_prio;
`else
         return 1'b0;
`endif
      end
      return req1_valid;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   task automatic model_reset();
      m_idle_from = 0; m_done_edge = -1;
      m_op = 0; m_a = 0; m_b = 0; m_lo = 0; m_hi = 0;
      m_id = 0; m_err = 0; m_prio = 0;
   endtask

   // One clock: compare before the edge, advance the model at the edge, return at the falling edge.
   task automatic step();
      logic g;
      bit   idle;
      int   l;
      #1;
      idle = (edge_no >= m_idle_from);
      g    = model_grant();
      if (armed) begin
         check("req0_ready", req0_ready, clear_n && idle && req0_valid && !g);
         check("req1_ready", req1_ready, clear_n && idle && req1_valid && g);
         check("resp_valid", resp_valid, edge_no == m_done_edge);
         check("resp_id", resp_id, m_id);
         check("resp_err", resp_err, m_err);
         check("lo", lo, m_lo);
         check("hi", hi, m_hi);
         check("alu_op", alu_op, m_op);
         check("alu_a", alu_a, m_a);
         check("alu_b", alu_b, m_b);
      end
      acc_seen = (req0_ready && req0_valid) || (req1_ready && req1_valid);
      @(posedge clock);
      if (!clear_n) begin
         model_reset();
         armed = 1;
      end else if (idle && (req0_valid || req1_valid)) begin
         m_op  = g ? req1_op : req0_op;
         m_a   = g ? req1_a  : req0_a;
         m_b   = g ? req1_b  : req0_b;
         l     = lat_of(m_op, m_b);
         p_err = is_err(m_op, m_b);
         {p_hi, p_lo} = p_err ? 64'd0 : alu_fn(m_op, m_a, m_b);
         p_id  = g;
         m_prio = !g;
         m_done_edge = edge_no + 1 + l;
         m_idle_from = edge_no + 1 + l + 1;
      end
      edge_no++;
      if (edge_no == m_done_edge) begin
         m_lo = p_lo; m_hi = p_hi; m_id = p_id; m_err = p_err;
      end
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0;
      req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
   endtask

   task automatic do_reset(input int n);
      clear_n = 0;
      repeat (n) step();
      clear_n = 1;
   endtask

   // Present one command, then check acceptance, latency (accept edge counts as 1) and the literal result.
   task automatic run_cmd(input string tag, input bit id, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi, input bit exp_err);
      int n;
      int lat;
      if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
      n = 0; acc_seen = 0;
      while (!acc_seen && n < 50) begin step(); n++; end
      check({tag, " accepted"}, acc_seen, 1);
      req0_valid = 0; req1_valid = 0;
      lat = 1;
      while (!resp_valid && lat < 40) begin step(); lat++; end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " lo"}, lo, exp_lo);
      check({tag, " hi"}, hi, exp_hi);
      check({tag, " id"}, resp_id, id);
      check({tag, " err"}, resp_err, exp_err);
   endtask

   initial begin
      int   n;
      logic ids [4];
      logic exp_ids [4];
      int   r;
      idle_inputs();
      do_reset(2);
      #1;
      check("reset alu_op", alu_op, 0);
      check("reset lo", lo, 0);
      check("reset resp_valid", resp_valid, 0);
      @(negedge clock);

      run_cmd("add", 0, 5'b00011, 32'd5, 32'd7, 2, 32'd12, 32'd0, 0);
      run_cmd("mul", 1, 5'b01111, 32'h00010000, 32'h00010000, MUL_C + 1, 32'd0, 32'd1, 0);
      run_cmd("div", 0, 5'b10000, 32'd17, 32'd5, DIV_C + 1, 32'd3, 32'd2, 0);
      run_cmd("div0", 0, 5'b10000, 32'd17, 32'd0, 2, 32'd0, 32'd0, 1);
      run_cmd("op12", 1, 5'b01100, 32'd9, 32'd4, 2, 32'd0, 32'd0, 1);

      // Both requesters held valid for four commands.
      do_reset(1);
      req0_valid = 1; req0_op = 5'd3; req0_a = 32'd1; req0_b = 32'd1;
      req1_valid = 1; req1_op = 5'd3; req1_a = 32'd2; req1_b = 32'd2;
`ifdef ALU_SEQ_CTRL_RR_EN
      exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (!resp_valid && n < 20) begin step(); n++; end
         ids[k] = resp_id;
         check("contention grant", ids[k], exp_ids[k]);
         step();
      end
      idle_inputs();

      // Reset two cycles into a divide; a requester waiting during reset must not be accepted.
      req0_valid = 1; req0_op = 5'd16; req0_a = 32'd100; req0_b = 32'd7;
      n = 0; acc_seen = 0;
      while (!acc_seen && n < 20) begin step(); n++; end
      req0_valid = 0;
      repeat (3) step();
      clear_n = 0;
      req1_valid = 1; req1_op = 5'd3; req1_a = 32'd4; req1_b = 32'd4;
      repeat (2) step();
      clear_n = 1; req1_valid = 0;
      #1;
      check("mid reset alu_op", alu_op, 0);
      check("mid reset alu_a", alu_a, 0);
      check("mid reset hi", hi, 0);
      check("mid reset resp_valid", resp_valid, 0);
      @(negedge clock);
      run_cmd("post reset add", 1, 5'b00011, 32'd1, 32'd2, 2, 32'd3, 32'd0, 0);
      run_cmd("illegal 31", 0, 5'b11111, 32'd6, 32'd6, 2, 32'd0, 32'd0, 1);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         clear_n    = ($urandom_range(0, 99) != 0);
         req0_valid = $urandom_range(0, 1) != 0;
         req1_valid = $urandom_range(0, 1) != 0;
         r = $urandom_range(0, 7);
         req0_op = (r == 0) ? 5'd15 : (r == 1) ? 5'd16 : 5'($urandom_range(0, 31));
         r = $urandom_range(0, 7);
         req1_op = (r == 0) ? 5'd15 : (r == 1) ? 5'd16 : 5'($urandom_range(0, 31));
         req0_a = $urandom; req1_a = $urandom;
         req0_b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         req1_b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         step();
      end
      clear_n = 1;
      idle_inputs();
      repeat (20) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4: EXEC cycles granted to op 01111 (mul), legal range 1..15.
REQ-002 SHALL have parameter DIV_CYCLES, default 8: EXEC cycles granted to op 10000 (div), legal range 1..15.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port clear_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester 0/1 holds a command.
REQ-006 SHALL have ports req0_op / req1_op  input  5  ALU opcode; req0_a, req0_b, req1_a, req1_b  input  32  operands.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  command accepted on this edge when valid is also high.
REQ-008 SHALL have ports alu_op  output  5, alu_a  output  32, alu_b  output  32  registered drive to the shared ALU.
REQ-009 SHALL have port alu_result  input  64  combinational ALU output.
REQ-010 SHALL have ports lo  output  32, hi  output  32  registered result (alu_result[31:0] / [63:32]).
REQ-011 SHALL have ports resp_valid  output  1, resp_id  output  1, resp_err  output  1  completion pulse, owner, error flag.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE.
REQ-013 In IDLE, ready SHALL be high only for the granted requester; both readys low outside IDLE.
REQ-014 Accept edge SHALL register op/a/b into alu_op/alu_a/alu_b, record resp_id, load counter with L-1, enter EXEC.
REQ-015 L SHALL be MUL_CYCLES for 01111, DIV_CYCLES for 10000, 1 for all other ops.
REQ-016 In EXEC, edge with counter 0 SHALL register lo/hi from alu_result, set resp_valid, enter DONE; otherwise counter decrements.
REQ-017 resp_valid SHALL be high exactly one cycle (DONE); resp_id/lo/hi hold until next completion.
REQ-018 Legal ops: 00011-01011, 01111, 10000, 10001, 10010; any other op SHALL use L=1, set resp_err, force lo=hi=0.
REQ-019 Op 10000 with b=0 SHALL use L=1, set resp_err, force lo=hi=0 (ALU divider output ignored).
REQ-020 resp_err SHALL be 0 on every other completion.
REQ-021 alu_op/alu_a/alu_b SHALL remain stable through EXEC and DONE.
REQ-022 Only one requester SHALL be requested: single valid wins immediately.
REQ-023 Both valid in IDLE: arbitration per REQ-029/030.
REQ-024 Throughput SHALL be one command per L+2 cycles; no queuing of a second command.

Reset
REQ-025 clear_n low at an edge SHALL force IDLE, counter 0, alu_op=0, alu_a=alu_b=0, lo=hi=0, resp_valid=resp_id=resp_err=0, RR pointer to requester 0.
REQ-026 Reset mid-EXEC SHALL abandon the command with no resp_valid; requester must re-present it.
REQ-027 Reset in same cycle as valid SHALL take precedence; no acceptance.
REQ-028 readys SHALL be low while clear_n is low.

Configuration
REQ-029 With ALU_SEQ_CTRL_RR_EN defined, SHALL use round-robin: on contention grant the requester not served last; pointer updates on each accept.
REQ-030 Without ALU_SEQ_CTRL_RR_EN, SHALL use fixed priority: requester 0 always wins contention.

Verification
REQ-031 req0 op 00011 a=5 b=7 -> resp_valid 2 edges after accept, lo=12, hi=0, resp_id=0, resp_err=0.
REQ-032 req1 op 01111 a=0x00010000 b=0x00010000, MUL_CYCLES=4 -> resp_valid 5 edges after accept, hi=1, lo=0, resp_id=1.
REQ-033 req0 op 10000 a=17 b=5 -> lo=3, hi=2 after DIV_CYCLES+1; repeat b=0 -> resp_err=1, lo=hi=0 after 2 edges.
REQ-034 req0 and req1 both held valid with op 00011 for 4 commands -> RR_EN: grants 0,1,0,1; no macro: 0,0,0,0.
REQ-035 clear_n low 2 cycles mid-EXEC of div -> no resp_valid, all outputs zero, next req accepted normally; op 11111 -> resp_err=1.
